// File: rtl/plataforma_sched_pkg.sv
// Shared definitions for the platform scheduler: game states, coordinate width, LFSR seed and taps.
package plataforma_sched_pkg;

  localparam int unsigned CW = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_OVER = 2'b10
  } plat_state_t;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/plataforma_sched_lfsr8.sv
// 8-bit Fibonacci LFSR that picks the height of each newly spawned platform.
module plat_lfsr8
  import plataforma_sched_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       adv,
  output logic [1:0] hsel
);

  logic [7:0] lfsr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  lfsr_q <= LFSR_SEED;
    else if (adv)  lfsr_q <= lfsr_next(lfsr_q);
  end

  assign hsel = lfsr_q[1:0];

endmodule

// File: rtl/plataforma_sched.sv
// Platform slot pool scheduler with IDLE/RUN/OVER game FSM.
// Optional PLAT_SPEEDUP_EN adds a level counter that raises scroll speed up to MAX_V.
module plataforma_sched
  import plataforma_sched_pkg::*;
#(
  parameter int unsigned NSLOT        = 4,
  parameter int unsigned SPAWN_X      = 780,
  parameter int unsigned LEFT_LIM     = 140,
  parameter int unsigned SPAWN_GAP    = 60,
  parameter int unsigned BAR_V        = 2,
`ifdef PLAT_SPEEDUP_EN
  parameter int unsigned MAX_V        = 8,
  parameter int unsigned LEVEL_FRAMES = 600,
`endif
  parameter int unsigned Y0           = 400,
  parameter int unsigned Y1           = 340,
  parameter int unsigned Y2           = 280,
  parameter int unsigned Y3           = 220
)(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                refr_tick,
  input  logic                start,
  input  logic [NSLOT-1:0]    stand_in,
  input  logic [NSLOT-1:0]    over_in,
  output logic [NSLOT-1:0]    slot_active,
  output logic [NSLOT*CW-1:0] slot_x,
  output logic [NSLOT*CW-1:0] slot_yt,
  output logic                stand_any,
  output logic [1:0]          state,
  output logic [3:0]          speed,
  output logic [15:0]         score
);

  localparam int unsigned GW = $clog2(SPAWN_GAP + 1);
  localparam logic [GW-1:0] GAP_TOP = GW'(SPAWN_GAP - 1);

  plat_state_t   state_q;
  logic [15:0]   score_q;
  logic [GW-1:0] gap_q;
  logic [1:0]    hsel;
  logic [CW-1:0] hy;
  logic [NSLOT-1:0] retire, spawn_sel;
  logic [3:0]    ret_cnt;
  logic          any_free;
  logic          tick_run;
  logic [16:0]   score_sum;

  plat_lfsr8 u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .adv     (refr_tick),
    .hsel    (hsel)
  );

  always_comb begin
    case (hsel)
      2'd0:    hy = CW'(Y0);
      2'd1:    hy = CW'(Y1);
      2'd2:    hy = CW'(Y2);
      default: hy = CW'(Y3);
    endcase
  end

  // Eligibility uses pre-tick activity, so a slot retiring this tick cannot be respawned until the next.
  always_comb begin
    retire    = '0;
    spawn_sel = '0;
    ret_cnt   = '0;
    any_free  = 1'b0;
    for (int unsigned i = 0; i < NSLOT; i++) begin
      if (slot_active[i] && (slot_x[i*CW +: CW] <= CW'(LEFT_LIM))) begin
        retire[i] = 1'b1;
        ret_cnt   = ret_cnt + 4'd1;
      end
      if (!slot_active[i] && !any_free) begin
        spawn_sel[i] = 1'b1;
        any_free     = 1'b1;
      end
    end
    if (gap_q != GAP_TOP) spawn_sel = '0;
  end

  assign tick_run  = (state_q == ST_RUN) && refr_tick;
  assign score_sum = {1'b0, score_q} + {13'b0, ret_cnt};

  for (genvar g = 0; g < NSLOT; g++) begin : slot_g
    logic          act_q;
    logic [CW-1:0] x_q, y_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        act_q <= 1'b0;
        x_q   <= '0;
        y_q   <= '0;
      end else if ((state_q == ST_IDLE) && start) begin
        act_q <= 1'b0;
      end else if (tick_run) begin
        if (act_q) begin
          if (retire[g]) act_q <= 1'b0;
          else           x_q   <= x_q - CW'(speed);
        end else if (spawn_sel[g]) begin
          act_q <= 1'b1;
          x_q   <= CW'(SPAWN_X);
          y_q   <= hy;
        end
      end
    end

    assign slot_active[g]       = act_q;
    assign slot_x[g*CW +: CW]   = x_q;
    assign slot_yt[g*CW +: CW]  = y_q;
  end

`ifdef PLAT_SPEEDUP_EN
  localparam int unsigned LW = $clog2(LEVEL_FRAMES + 1);
  logic [LW-1:0] lvl_q;
  logic [3:0]    speed_q;
  assign speed = speed_q;
`else
  assign speed = 4'(BAR_V);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      score_q <= '0;
      gap_q   <= GAP_TOP;
`ifdef PLAT_SPEEDUP_EN
      lvl_q   <= '0;
      speed_q <= 4'(BAR_V);
`endif
    end else begin
      case (state_q)
        ST_IDLE: if (start) begin
          state_q <= ST_RUN;
          score_q <= '0;
          gap_q   <= GAP_TOP;
`ifdef PLAT_SPEEDUP_EN
          lvl_q   <= '0;
          speed_q <= 4'(BAR_V);
`endif
        end
        ST_RUN: begin
          if (refr_tick) begin
            score_q <= score_sum[16] ? '1 : score_sum[15:0];
            if (gap_q == GAP_TOP) begin
              if (any_free) gap_q <= '0;
            end else begin
              gap_q <= gap_q + 1'b1;
            end
`ifdef PLAT_SPEEDUP_EN
            if (lvl_q == LW'(LEVEL_FRAMES - 1)) begin
              lvl_q <= '0;
              if (speed_q < 4'(MAX_V)) speed_q <= speed_q + 4'd1;
            end else begin
              lvl_q <= lvl_q + 1'b1;
            end
`endif
          end
          if (|(over_in & slot_active)) state_q <= ST_OVER;
        end
        ST_OVER: if (start) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign state     = state_q;
  assign score     = score_q;
  assign stand_any = |(stand_in & slot_active);

endmodule
